bist_controller: RTL

// - Test sequencer that drives the BIST datapath (LFSR pattern generator -> CUT -> MISR)

---
 rtl/bist_controller_pkg.sv | 22 ++
 rtl/bist_controller_pattern_counter.sv | 29 ++
 rtl/bist_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bist_controller_pkg.sv
// Shared definitions for the BIST test sequencer: state encodings and default
// signature parameters used by the controller and anything that observes it.
package bist_controller_pkg;

   typedef enum logic [2:0] {
      BIST_IDLE    = 3'd0,
      BIST_CLEAR   = 3'd1,
      BIST_RUN     = 3'd2,
      BIST_SETTLE  = 3'd3,
      BIST_COMPARE = 3'd4,
      BIST_DONE    = 3'd5
   } bist_state_t;

   localparam int                       DEFAULT_SIG_W      = 4;
   localparam logic [DEFAULT_SIG_W-1:0] DEFAULT_GOLDEN_SIG = 4'hA;

   // True in the states where a new start request may be accepted.
   function automatic logic can_start(input bist_state_t s);
      return (s == BIST_IDLE) || (s == BIST_DONE);
   endfunction

endpackage

// File: rtl/bist_controller_pattern_counter.sv
// Pattern counter for the BIST run phase: up-counter with synchronous clear,
// advance enable and a terminal flag on the last pattern of the run.
module bist_pattern_counter #(
   parameter int PATTERN_COUNT = 255,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             terminal
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERN_COUNT - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign terminal = (count == LAST_CNT);

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: clears the LFSR/MISR datapath, runs a fixed number of pattern
// cycles, lets the MISR settle, then judges the captured signature.
module bist_controller
   import bist_controller_pkg::*;
#(
   parameter int               PATTERN_COUNT = 255,
   parameter int               CNT_W         = 8,
   parameter int               SIG_W         = DEFAULT_SIG_W,
   parameter logic [SIG_W-1:0] GOLDEN_SIG    = SIG_W'(DEFAULT_GOLDEN_SIG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [SIG_W-1:0] sig_in,
   output logic             bist_clr,
   output logic             bist_en,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             aborted,
   output logic [CNT_W-1:0] cycles_run
);

   if (PATTERN_COUNT < 1) begin : g_bad_pattern_count
      $error("bist_controller: PATTERN_COUNT must be at least 1");
   end
   if ((64'd1 << CNT_W) <= 64'(PATTERN_COUNT)) begin : g_bad_cnt_w
      $error("bist_controller: CNT_W too narrow for PATTERN_COUNT");
   end

   bist_state_t      state_reg;
   logic [SIG_W-1:0] sig_reg;
   logic             start_accept;
   logic             cnt_en;
   logic             cnt_terminal;

   assign start_accept = can_start(state_reg) && start && !abort;
   // The counter doubles as cycles_run; gating with abort freezes it on the
   // edge that terminates the run.
   assign cnt_en       = (state_reg == BIST_RUN) && !abort;

   bist_pattern_counter #(
      .PATTERN_COUNT (PATTERN_COUNT),
      .CNT_W         (CNT_W)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_accept),
      .en       (cnt_en),
      .count    (cycles_run),
      .terminal (cnt_terminal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= BIST_IDLE;
         bist_clr  <= 1'b0;
         bist_en   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         sig_reg   <= '0;
      end else begin
         bist_clr <= 1'b0;
         bist_en  <= 1'b0;
         case (state_reg)
            BIST_IDLE, BIST_DONE: begin
               if (start_accept) begin
                  state_reg <= BIST_CLEAR;
                  bist_clr  <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  aborted   <= 1'b0;
                  sig_reg   <= '0;
               end
            end
            BIST_CLEAR, BIST_RUN, BIST_SETTLE, BIST_COMPARE: begin
               if (abort) begin
                  state_reg <= BIST_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  aborted   <= 1'b1;
               end else begin
                  case (state_reg)
                     BIST_CLEAR: begin
                        state_reg <= BIST_RUN;
                        bist_en   <= 1'b1;
                     end
                     BIST_RUN: begin
                        if (cnt_terminal) begin
                           state_reg <= BIST_SETTLE;
                        end else begin
                           bist_en <= 1'b1;
                        end
                     end
                     BIST_SETTLE: begin
                        state_reg <= BIST_COMPARE;
                        busy      <= 1'b0;
                     end
                     default: begin
                        state_reg <= BIST_DONE;
                        done      <= 1'b1;
                        sig_reg   <= sig_in;
                     end
                  endcase
               end
            end
            default: begin
               state_reg <= BIST_IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               aborted   <= 1'b0;
            end
         endcase
      end
   end

   // Verdict decoded from registered state only; both flags stay low unless done.
   assign pass = done && !aborted && (sig_reg == GOLDEN_SIG);
   assign fail = done && !pass;

endmodule
